// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: RX byte-frame decoder that drives an ALU and
// forwards each result to the transmitter, with ALU timeout.
module alu_cmd_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int FUN_WIDTH   = 4,
   parameter int TIMEOUT_CYC = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic [DATA_WIDTH-1:0] ALU_A,
   output logic [DATA_WIDTH-1:0] ALU_B,
   output logic [FUN_WIDTH-1:0]  ALU_FUN,
   output logic                  ALU_EN,
   input  logic [DATA_WIDTH-1:0] ALU_OUT,
   input  logic                  ALU_OUT_VLD,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_BUSY,
   output logic                  FRAME_ERR
);

   localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   localparam logic [DATA_WIDTH-1:0] CMD_AB  = DATA_WIDTH'('hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'('hDD);
   localparam logic [CW-1:0]         TO_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      GET_A,
      GET_B,
      GET_FUN,
      WAIT_RES,
      SEND
   } state_t;

   state_t        state;
   logic [CW-1:0] to_cnt;

   // Frame FSM with registered operands, strobes and result.
   // TX_P_DATA doubles as the result register: it is loaded once at
   // capture and held until the strobe, even under back-pressure.
   // The timeout counter is frozen while ALU_EN is still high so
   // counting starts on the edge after ALU_EN falls.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         to_cnt    <= '0;
         ALU_A     <= '0;
         ALU_B     <= '0;
         ALU_FUN   <= '0;
         ALU_EN    <= 1'b0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         ALU_EN    <= 1'b0;
         TX_D_VLD  <= 1'b0;
         FRAME_ERR <= 1'b0;
         unique case (state)
            IDLE: begin
               if (RX_D_VLD) begin
                  if (RX_P_DATA == CMD_AB) begin
                     state <= GET_A;
                  end else if (RX_P_DATA == CMD_FUN) begin
                     state <= GET_FUN;
                  end else begin
                     FRAME_ERR <= 1'b1;
                  end
               end
            end
            GET_A: begin
               if (RX_D_VLD) begin
                  ALU_A <= RX_P_DATA;
                  state <= GET_B;
               end
            end
            GET_B: begin
               if (RX_D_VLD) begin
                  ALU_B <= RX_P_DATA;
                  state <= GET_FUN;
               end
            end
            GET_FUN: begin
               if (RX_D_VLD) begin
                  ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                  ALU_EN  <= 1'b1;
                  to_cnt  <= '0;
                  state   <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               if (ALU_OUT_VLD) begin
                  TX_P_DATA <= ALU_OUT;
                  to_cnt    <= '0;
                  if (!TX_BUSY) begin
                     TX_D_VLD <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     state <= SEND;
                  end
               end else if (!ALU_EN) begin
                  if (to_cnt == TO_LAST) begin
                     FRAME_ERR <= 1'b1;
                     to_cnt    <= '0;
                     state     <= IDLE;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
            end
            SEND: begin
               if (!TX_BUSY) begin
                  TX_D_VLD <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: table vectors, timing sequences and random
// frames checked against a frame-level model of the controller.
module tb_alu_cmd_ctrl;

   localparam int TO = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] RX_P_DATA = 8'h00;
   logic       RX_D_VLD = 1'b0;
   logic [7:0] ALU_A;
   logic [7:0] ALU_B;
   logic [3:0] ALU_FUN;
   logic       ALU_EN;
   logic [7:0] ALU_OUT = 8'h00;
   logic       ALU_OUT_VLD = 1'b0;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;
   logic       TX_BUSY = 1'b0;
   logic       FRAME_ERR;

   always #5 CLK = ~CLK;

   alu_cmd_ctrl #(
      .DATA_WIDTH (8),
      .FUN_WIDTH  (4),
      .TIMEOUT_CYC(TO)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_P_DATA  (RX_P_DATA),
      .RX_D_VLD   (RX_D_VLD),
      .ALU_A      (ALU_A),
      .ALU_B      (ALU_B),
      .ALU_FUN    (ALU_FUN),
      .ALU_EN     (ALU_EN),
      .ALU_OUT    (ALU_OUT),
      .ALU_OUT_VLD(ALU_OUT_VLD),
      .TX_P_DATA  (TX_P_DATA),
      .TX_D_VLD   (TX_D_VLD),
      .TX_BUSY    (TX_BUSY),
      .FRAME_ERR  (FRAME_ERR)
   );

   int errors = 0;
   int checks = 0;
   int en_cnt = 0;
   int tx_cnt = 0;
   int err_cnt = 0;
   int consec_viol = 0;
   int busy_viol = 0;
   logic en_prev = 1'b0;
   logic tx_prev = 1'b0;
   logic [7:0] txq[$];
   int lat = 1;
   int alu_cd = 0;
   bit busy_force = 1'b0;
   bit busy_rand = 1'b0;

   function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b,
                                        logic [3:0] f);
      case (f)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a | b;
         4'd3: return a ^ b;
         4'd4: return a & b;
         default: return (a << 1) ^ b ^ {4'h0, f};
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor, ALU (latency lat cycles, 0 = never answers) and TX_BUSY.
   always @(negedge CLK) begin
      if (ALU_EN) en_cnt++;
      if (ALU_EN && en_prev) consec_viol++;
      en_prev = ALU_EN;
      if (TX_D_VLD) begin
         tx_cnt++;
         txq.push_back(TX_P_DATA);
         if (TX_BUSY) busy_viol++;
         if (tx_prev) consec_viol++;
      end
      tx_prev = TX_D_VLD;
      if (FRAME_ERR) err_cnt++;
      ALU_OUT_VLD = 1'b0;
      if (alu_cd > 0) begin
         alu_cd--;
         if (alu_cd == 0) begin
            ALU_OUT_VLD = 1'b1;
            ALU_OUT = alu_f(ALU_A, ALU_B, ALU_FUN);
         end
      end
      if (ALU_EN && lat > 0) alu_cd = lat;
      TX_BUSY = busy_force | (busy_rand && $urandom_range(0, 3) == 0);
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD = 1'b1;
      @(negedge CLK);
      RX_D_VLD = 1'b0;
   endtask

   task automatic settle(input int base);
      int n = 0;
      while ((tx_cnt + err_cnt) == base && n < 80) begin
         @(negedge CLK);
         n++;
      end
      repeat (8) @(negedge CLK);
   endtask

   typedef struct {
      int             nb;
      logic [3:0][7:0] bytes;
      int             lat;
      logic [7:0]     ea;
      logic [7:0]     eb;
      logic [3:0]     ef;
      int             etx_n;
      logic [7:0]     etx;
      int             eerr_n;
      int             een_n;
   } vec_t;

   task automatic run_vec(input vec_t v, input int idx);
      int e0, t0, r0;
      e0 = en_cnt;
      t0 = tx_cnt;
      r0 = err_cnt;
      lat = v.lat;
      for (int i = 0; i < v.nb; i++) send_byte(v.bytes[3-i]);
      settle(t0 + r0);
      check($sformatf("v%0d_en", idx), en_cnt - e0, v.een_n);
      check($sformatf("v%0d_txn", idx), tx_cnt - t0, v.etx_n);
      check($sformatf("v%0d_err", idx), err_cnt - r0, v.eerr_n);
      if (v.etx_n == 1)
         check($sformatf("v%0d_txd", idx), int'(TX_P_DATA), int'(v.etx));
      check($sformatf("v%0d_a", idx), int'(ALU_A), int'(v.ea));
      check($sformatf("v%0d_b", idx), int'(ALU_B), int'(v.eb));
      check($sformatf("v%0d_f", idx), int'(ALU_FUN), int'(v.ef));
   endtask

   vec_t vt[8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, t0, r0;
      logic [7:0] ma, mb, fb, jb, exp_d;
      bit ok, cc;
      int k;

      vt[0] = '{4, {8'hCC, 8'h05, 8'h03, 8'h00}, 1,
                8'h05, 8'h03, 4'h0, 1, 8'h08, 0, 1};
      vt[1] = '{2, {8'hDD, 8'h01, 8'h00, 8'h00}, 1,
                8'h05, 8'h03, 4'h1, 1, 8'h02, 0, 1};
      vt[2] = '{1, {8'h55, 8'h00, 8'h00, 8'h00}, 1,
                8'h05, 8'h03, 4'h1, 0, 8'h00, 1, 0};
      vt[3] = '{2, {8'hDD, 8'h04, 8'h00, 8'h00}, 1,
                8'h05, 8'h03, 4'h4, 1, 8'h01, 0, 1};
      vt[4] = '{4, {8'hCC, 8'h01, 8'h01, 8'h0F}, 0,
                8'h01, 8'h01, 4'hF, 0, 8'h00, 1, 1};
      vt[5] = '{4, {8'hCC, 8'h10, 8'h20, 8'h00}, 4,
                8'h10, 8'h20, 4'h0, 1, 8'h30, 0, 1};
      vt[6] = '{4, {8'hCC, 8'h10, 8'h20, 8'h02}, 5,
                8'h10, 8'h20, 4'h2, 0, 8'h00, 1, 1};
      vt[7] = '{2, {8'hDD, 8'h13, 8'h00, 8'h00}, 2,
                8'h10, 8'h20, 4'h3, 1, 8'h30, 0, 1};

      #1;
      check("rst_a", int'(ALU_A), 0);
      check("rst_txd", int'(TX_P_DATA), 0);
      check("rst_strobes", int'({ALU_EN, TX_D_VLD, FRAME_ERR}), 0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      for (int i = 0; i < 8; i++) run_vec(vt[i], i);

      // Nominal latency: TX strobe two edges after the FUN edge.
      lat = 1;
      send_byte(8'hCC);
      send_byte(8'h05);
      send_byte(8'h03);
      @(negedge CLK);
      RX_P_DATA = 8'h00;
      RX_D_VLD = 1'b1;
      @(negedge CLK);
      RX_D_VLD = 1'b0;
      check("lat_en_e0", ALU_EN, 1);
      check("lat_tx_e0", TX_D_VLD, 0);
      @(negedge CLK);
      check("lat_en_e1", ALU_EN, 0);
      check("lat_tx_e1", TX_D_VLD, 0);
      @(negedge CLK);
      check("lat_tx_e2", TX_D_VLD, 1);
      check("lat_txd_e2", int'(TX_P_DATA), 8'h08);
      @(negedge CLK);
      check("lat_tx_e3", TX_D_VLD, 0);
      repeat (8) @(negedge CLK);

      // Timeout: FRAME_ERR four edges after ALU_EN falls.
      lat = 0;
      t0 = tx_cnt;
      send_byte(8'hCC);
      send_byte(8'h01);
      send_byte(8'h01);
      @(negedge CLK);
      RX_P_DATA = 8'h0F;
      RX_D_VLD = 1'b1;
      @(negedge CLK);
      RX_D_VLD = 1'b0;
      check("to_en_e0", ALU_EN, 1);
      @(negedge CLK);
      check("to_en_e1", ALU_EN, 0);
      repeat (3) @(negedge CLK);
      check("to_err_e4", FRAME_ERR, 0);
      @(negedge CLK);
      check("to_err_e5", FRAME_ERR, 1);
      @(negedge CLK);
      check("to_err_e6", FRAME_ERR, 0);
      repeat (8) @(negedge CLK);
      check("to_no_tx", tx_cnt - t0, 0);

      // Back-pressure with RX bytes dropped while waiting.
      lat = 1;
      t0 = tx_cnt;
      e0 = en_cnt;
      send_byte(8'hCC);
      send_byte(8'h05);
      @(posedge CLK);
      busy_force = 1'b1;
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'hCC);
      send_byte(8'hDD);
      send_byte(8'h05);
      repeat (4) @(negedge CLK);
      check("bp_no_tx", tx_cnt - t0, 0);
      check("bp_held", int'(TX_P_DATA), 8'h08);
      @(posedge CLK);
      busy_force = 1'b0;
      @(negedge CLK);
      check("bp_tx_pre", TX_D_VLD, 0);
      @(negedge CLK);
      check("bp_tx", TX_D_VLD, 1);
      check("bp_txd", int'(TX_P_DATA), 8'h08);
      repeat (6) @(negedge CLK);
      check("bp_txn", tx_cnt - t0, 1);
      check("bp_enn", en_cnt - e0, 1);
      r0 = err_cnt;
      t0 = tx_cnt;
      send_byte(8'hDD);
      send_byte(8'h01);
      settle(t0 + r0);
      check("bp_next_txn", tx_cnt - t0, 1);
      check("bp_next_txd", int'(TX_P_DATA), 8'h02);

      // Reset mid-frame discards the frame and clears operands.
      send_byte(8'hCC);
      send_byte(8'h05);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("mr_a", int'(ALU_A), 0);
      check("mr_b", int'(ALU_B), 0);
      check("mr_f", int'(ALU_FUN), 0);
      check("mr_txd", int'(TX_P_DATA), 0);
      check("mr_strobes", int'({ALU_EN, TX_D_VLD, FRAME_ERR}), 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      e0 = en_cnt;
      t0 = tx_cnt;
      repeat (6) @(negedge CLK);
      check("mr_no_en", en_cnt - e0, 0);
      r0 = err_cnt;
      send_byte(8'hDD);
      send_byte(8'h00);
      settle(t0 + r0);
      check("mr_txn", tx_cnt - t0, 1);
      check("mr_txd2", int'(TX_P_DATA), 0);

      // Random frames against the frame-level model.
      ma = 8'h00;
      mb = 8'h00;
      busy_rand = 1'b1;
      for (int it = 0; it < 150; it++) begin
         e0 = en_cnt;
         t0 = tx_cnt;
         r0 = err_cnt;
         txq.delete();
         k = $urandom_range(0, 9);
         if (k == 0) begin
            do jb = 8'($urandom_range(0, 255));
            while (jb == 8'hCC || jb == 8'hDD);
            send_byte(jb);
            settle(t0 + r0);
            check("rnd_j_err", err_cnt - r0, 1);
            check("rnd_j_en", en_cnt - e0, 0);
            check("rnd_j_tx", tx_cnt - t0, 0);
         end else begin
            cc = (k < 6);
            fb = 8'($urandom_range(0, 255));
            lat = $urandom_range(0, 6);
            if (cc) begin
               ma = 8'($urandom_range(0, 255));
               mb = 8'($urandom_range(0, 255));
               send_byte(8'hCC);
               send_byte(ma);
               send_byte(mb);
            end else begin
               send_byte(8'hDD);
            end
            send_byte(fb);
            ok = (lat >= 1 && lat <= TO);
            exp_d = alu_f(ma, mb, fb[3:0]);
            settle(t0 + r0);
            check("rnd_en", en_cnt - e0, 1);
            check("rnd_txn", tx_cnt - t0, ok ? 1 : 0);
            check("rnd_err", err_cnt - r0, ok ? 0 : 1);
            if (ok && txq.size() > 0)
               check("rnd_txd", int'(txq[0]), int'(exp_d));
            check("rnd_f", int'(ALU_FUN), int'(fb[3:0]));
         end
         check("rnd_a", int'(ALU_A), int'(ma));
         check("rnd_b", int'(ALU_B), int'(mb));
      end
      busy_rand = 1'b0;
      repeat (4) @(negedge CLK);

      check("consec_strobe", consec_viol, 0);
      check("tx_while_busy", busy_viol, 0);
      check("tx_le_en", int'(tx_cnt <= en_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of RX bytes, operands, result and TX data.
REQ-002 Parameter FUN_WIDTH, default 4, width of the ALU function code.
REQ-003 Parameter TIMEOUT_CYC, default 4, cycles allowed for ALU_OUT_VLD after ALU_EN falls.
REQ-004 CLK  in  1  system clock, all logic on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 RX_P_DATA  in  DATA_WIDTH  received byte.
REQ-007 RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid while high.
REQ-008 ALU_A, ALU_B  out  DATA_WIDTH each  operand registers driven to the ALU.
REQ-009 ALU_FUN  out  FUN_WIDTH  function code driven to the ALU.
REQ-010 ALU_EN  out  1  ALU enable, one-cycle pulse per operation.
REQ-011 ALU_OUT  in  DATA_WIDTH  ALU result.
REQ-012 ALU_OUT_VLD  in  1  ALU result-valid strobe.
REQ-013 TX_P_DATA  out  DATA_WIDTH  result byte to the transmitter.
REQ-014 TX_D_VLD  out  1  one-cycle strobe; TX_P_DATA is valid while high.
REQ-015 TX_BUSY  in  1  transmitter busy; no TX_D_VLD may be issued while high.
REQ-016 FRAME_ERR  out  1  one-cycle error pulse.
REQ-017 All outputs SHALL be registered.

Function
REQ-018 Frame 0xCC, A, B, FUN: load ALU_A, ALU_B and ALU_FUN, then run the ALU.
REQ-019 Frame 0xDD, FUN: load ALU_FUN only and run the ALU with the retained ALU_A and ALU_B.
REQ-020 FSM states: IDLE, GET_A, GET_B, GET_FUN, WAIT_RES, SEND.
REQ-021 Transitions occur only on edges where RX_D_VLD=1, except from WAIT_RES and SEND.
- IDLE: 0xCC -> GET_A; 0xDD -> GET_FUN.
- GET_A -> GET_B.
- GET_B -> GET_FUN.
- GET_FUN -> WAIT_RES.
REQ-022 IDLE receiving any byte other than 0xCC/0xDD: FRAME_ERR=1 for exactly one cycle, stay IDLE, no ALU_EN.
REQ-023 At the edge that samples the FUN byte: ALU_FUN <= byte[FUN_WIDTH-1:0]; ALU_EN <= 1. ALU_EN returns to 0 on the next edge.
REQ-024 ALU_A, ALU_B and ALU_FUN SHALL hold their values between frames; only the relevant frame bytes update them.
REQ-025 In WAIT_RES, the first edge sampling ALU_OUT_VLD=1 captures ALU_OUT into a result register.
- TX_BUSY=0 at that edge: TX_D_VLD <= 1, TX_P_DATA <= ALU_OUT, next state IDLE.
- Otherwise: next state SEND.
REQ-026 Nominal latency: with an ALU of one-cycle latency and TX_BUSY=0, TX_D_VLD is high 2 edges after the FUN-byte edge.
REQ-027 In SEND, at the first edge sampling TX_BUSY=0: TX_D_VLD=1 for one cycle with the captured result, then -> IDLE. TX_P_DATA SHALL be stable from capture until the strobe.
REQ-028 WAIT_RES timeout:
- Counter starts when ALU_EN falls.
- If ALU_OUT_VLD is not seen within TIMEOUT_CYC edges: FRAME_ERR pulse for one cycle, -> IDLE, no TX_D_VLD.
REQ-029 RX_D_VLD is ignored in WAIT_RES and SEND; such bytes are dropped silently and SHALL NOT start a frame.
REQ-030 ALU_OUT_VLD outside WAIT_RES SHALL be ignored.
REQ-031 TX_D_VLD and ALU_EN SHALL never be high for two consecutive cycles.
REQ-032 At most one TX_D_VLD SHALL be issued per ALU_EN.

Reset
REQ-033 RST=0 forces immediately, regardless of state:
- FSM to IDLE.
- ALU_A, ALU_B, ALU_FUN, TX_P_DATA to 0.
- ALU_EN, TX_D_VLD, FRAME_ERR to 0.
- Timeout counter to 0.
REQ-034 A partial frame in progress when RST asserts SHALL be discarded; no ALU_EN or TX_D_VLD may follow it after reset release.

Verification
REQ-035 Basic operation:
- Stimulus: 0xCC, 0x05, 0x03, 0x00; ALU model adds with one-cycle latency.
- Response: ALU_A=0x05, ALU_B=0x03, ALU_FUN=0x0; one ALU_EN pulse; TX_P_DATA=0x08 with a single TX_D_VLD 2 edges after the FUN byte.
REQ-036 Operand reuse:
- Stimulus: 0xDD, 0x01 after REQ-035.
- Response: operands stay 0x05/0x03; TX_P_DATA=0x02.
REQ-037 Unknown command:
- Stimulus: byte 0x55 in IDLE, then 0xDD, 0x04.
- Response: FRAME_ERR pulses one cycle with no ALU_EN; the following frame yields TX_P_DATA=0x01.
REQ-038 Transmitter back-pressure:
- Stimulus: TX_BUSY=1 for 10 cycles around result capture during REQ-035.
- Response: no TX_D_VLD while busy; one TX_D_VLD with 0x08 on the first edge with TX_BUSY=0; RX bytes sent meanwhile are dropped.
REQ-039 ALU timeout:
- Stimulus: 0xCC, 0x01, 0x01, 0x0F; ALU never asserts valid.
- Response: FRAME_ERR pulse 4 edges after ALU_EN falls; no TX_D_VLD; FSM in IDLE.
REQ-040 Reset mid-frame:
- Stimulus: RST low after 0xCC, 0x05; release; then send 0xDD, 0x00.
- Response: all outputs 0 during reset; TX_P_DATA=0x00 (A=B=0).
